muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised, multi-cycle RISC-V M-extension unit for the execute stage. It replaces the fixed 64-bit multiply and divide helpers with one block covering every M-extension operation:
- the full MUL/MULH/MULHSU/MULHU set;
- DIV/DIVU/REM/REMU;
- the RV64 W variants.

It uses a valid/ready handshake in both directions, has a configurable multiplier throughput and supports a pipeline flush. The execute stage stalls on `in_ready`/`out_valid` instead of a bubble flag.

## Interface
- `XLEN`, 64, datapath width; must be 32 or 64.
- `MUL_BPC`, 4, multiplier bits retired per cycle; must divide 32.
- `clk` input 1 — clock.
- `reset_n` input 1 — reset, asynchronous, active-low.
- `flush` input 1 — abort the current operation and drop any held result.
- `in_valid` input 1 — request present.
- `in_ready` output 1 — unit idle and able to accept a request.
- `op` input 3 — operation code `mdop_t`, RISC-V funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `word` input 1 — W variant; ignored when `XLEN`=32.
- `srca` input XLEN — rs1.
- `srcb` input XLEN — rs2.
- `out_valid` output 1 — result available.
- `out_ready` input 1 — consumer takes the result.
- `result` output XLEN — result, held stable while `out_valid` is high.

## Operation
- States: IDLE, MUL, DIV, FIXUP, DONE.
- Reset puts the unit in IDLE.
- Outputs at reset: `in_ready`=1, `out_valid`=0, `result`=0.
- `in_ready` = (state==IDLE). A request is accepted on a cycle with `in_valid && in_ready && !flush`; operands and op are latched on that edge.
- Operand width W_EFF = 32 when `word`=1, otherwise XLEN. With `word`=1 only the low 32 bits of each operand are used, and the final result is sign-extended from bit 31. This applies to DIVUW and REMUW as well.
- Legal W ops: MUL, DIV, DIVU, REM, REMU. With `word`=1, ops 1-3 produce result 0 via the one-cycle path.
- **Multiply path**
  - Shift-add over magnitudes with a 2·W_EFF product register, retiring `MUL_BPC` bits per cycle for W_EFF/`MUL_BPC` cycles.
  - Signedness follows the op: MULH is signed×signed, MULHSU is signed×unsigned, MULHU and MUL are unsigned.
  - The product sign is applied in the last iteration.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- **Divide path**
  - Restoring radix-2 divide on magnitudes, one quotient bit per cycle for W_EFF cycles.
  - FIXUP then negates the quotient when the operand signs differ, and negates the remainder to the dividend's sign.
- **Special cases** (one cycle, IDLE→DONE directly)
  - Divide by zero (divisor == 0 over W_EFF bits): quotient = all ones, remainder = dividend.
  - Signed overflow (dividend = −2^(W_EFF−1) and divisor = −1): quotient = dividend, remainder = 0.
- DONE: `out_valid`=1 and `result` is held. Leave DONE for IDLE on `out_ready`.
- **Flush**
  - Active in any state: go to IDLE on the next edge and drop `out_valid`; no result is ever produced for the aborted op.
  - Flush has priority over both accept and `out_ready`.

## Timing
- Latency is counted from the accept edge E0 to the edge at which `out_valid` rises.
- Multiply: W_EFF/`MUL_BPC` cycles. With the default `MUL_BPC`=4, that is 16 cycles for 64-bit ops and 8 for W ops.
- Divide: W_EFF+1 cycles, i.e. 65 cycles for 64-bit ops and 33 for W ops.
- Special cases: 1 cycle.
- `out_valid` and `out_ready` both high at edge E: the result is consumed, and `in_ready` is 1 from E onward.
- A new request can therefore be accepted one cycle after consumption; there is no back-to-back accept in the same cycle as consumption.
- `result` is registered and changes only on the transition into DONE.
- Outputs while not in DONE: `result` keeps its last value and `out_valid` is 0.
- Reset asserted mid-operation: the unit is immediately in IDLE with reset output values; the operation is lost.
- The iteration counter is log2(XLEN)+1 bits wide and is reloaded on every accept, so no wrap-around state carries over between ops.

## Structure
- `mdop_t` enum and the state enum go in the shared `pipes` package.
- The W-select / sign-extend helper goes in `common`.
- Sub-module `muldiv_divcore`: the restoring divide iteration plus the FIXUP sign correction. It owns the quotient, remainder and divisor registers and has start/done pulses.
- Multiply datapath, state machine, special-case detection and output register stay in `muldiv_unit`.

## Test plan
- **MUL, 64-bit, no stall:** XLEN=64, MUL, srca=0xFFFF_FFFF_FFFF_FFFF, srcb=2, out_ready=1.
  - `result`=0xFFFF_FFFF_FFFF_FFFE, with `out_valid` high 16 cycles after accept.
  - MULH on the same operands gives 0xFFFF_FFFF_FFFF_FFFF.
  - MULHU on the same operands gives 1.
- **DIV, signed:** srca=−7, srcb=2.
  - DIV gives −3 after 65 cycles.
  - REM gives −1.
  - DIVU of 7/2 gives 3.
  - REMUW of 0x1_8000_0001 by 2 gives 1.
- **Divide by zero:** DIV 5/0 gives 0xFFFF_FFFF_FFFF_FFFF and REM 5/0 gives 5, each 1 cycle after accept.
- **Signed overflow:** DIV 0x8000_0000_0000_0000 / −1 gives 0x8000_0000_0000_0000 and REM gives 0, each in 1 cycle.
  - DIVW 0x8000_0000 / −1 gives 0xFFFF_FFFF_8000_0000.
- **Back-pressure:** hold out_ready=0 for 10 cycles after `out_valid` rises.
  - `result` stays stable and `in_ready` stays 0.
  - Raising out_ready consumes the result, `in_ready`=1 on the next cycle, and a new accept follows.
- **Flush and reset:**
  - Flush on cycle 20 of a DIV: IDLE next cycle, `out_valid` never rises, and a following MULW 3×−4 returns 0xFFFF_FFFF_FFFF_FFF4 in 8 cycles.
  - reset_n pulsed low mid-MUL gives `out_valid`=0, `in_ready`=1 and `result`=0 asynchronously.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared op/state types and W-variant operand helper
package pipes;
   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } mdop_t;
   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} md_state_t;
endpackage

package common;
   // Keep the low word and extend it (signed or zero) when w is set, else pass through
   function automatic logic [63:0] wext(input logic [63:0] v, input logic w, input logic s);
      return w ? {{32{s & v[31]}}, v[31:0]} : v;
   endfunction
endpackage

// File: rtl/muldiv_divcore.sv
// muldiv_divcore: restoring radix-2 divider on magnitudes with quotient/remainder sign fixup
module muldiv_divcore #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            start,
   input  logic            word,
   input  logic            neg_quo,
   input  logic            neg_rem,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quo,
   output logic [XLEN-1:0] rem
);
   localparam int CW = $clog2(XLEN) + 1;
   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d, nq_q, nq_d, nr_q, nr_d, ge;
   logic [XLEN:0]   sh;

   // One quotient bit per cycle; a W dividend is pre-shifted so its bit 31 enters first
   always_comb begin
      sh     = {rem_q, quo_q[XLEN-1]};
      ge     = sh >= {1'b0, dvs_q};
      done   = busy_q && cnt_q == '0;
      rem_d  = busy_q ? (ge ? sh[XLEN-1:0] - dvs_q : sh[XLEN-1:0]) : rem_q;
      quo_d  = busy_q ? {quo_q[XLEN-2:0], ge} : quo_q;
      cnt_d  = busy_q ? cnt_q - 1'b1 : cnt_q;
      busy_d = busy_q && !done && !flush;
      dvs_d  = dvs_q;
      nq_d   = nq_q;
      nr_d   = nr_q;
      if (start) begin
         rem_d  = '0;
         quo_d  = word ? dividend << (XLEN - 32) : dividend;
         dvs_d  = divisor;
         cnt_d  = CW'((word ? 32 : XLEN) - 1);
         busy_d = 1'b1;
         nq_d   = neg_quo;
         nr_d   = neg_rem;
      end
   end

   // Divider registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         nq_q   <= 1'b0;
         nr_q   <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         nq_q   <= nq_d;
         nr_q   <= nr_d;
      end
   end

   assign quo = nq_q ? -quo_q : quo_q;
   assign rem = nr_q ? -rem_q : rem_q;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RISC-V M-extension multiply/divide unit with valid/ready and flush
module muldiv_unit
   import pipes::*;
   import common::*;
#(
   parameter int XLEN    = 64,
   parameter int MUL_BPC = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  mdop_t           op,
   input  logic            word,
   input  logic [XLEN-1:0] srca,
   input  logic [XLEN-1:0] srcb,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN) + 1;
   md_state_t         state_q, state_d;
   mdop_t             op_q, op_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] prod_q, prod_d, p;
   logic [XLEN-1:0]   mcand_q, mcand_d, result_q, result_d;
   logic              word_q, word_d, neg_q, neg_d;
   logic              w, sa, sb, na, nb, b_zero, ovf, special, div_start, div_done;
   logic [XLEN-1:0]   ea, eb, ma, mb, spec_r, mul_r, q_fix, r_fix;
   logic [XLEN:0]     s;

   // Decode the request: operand extension, magnitudes and one-cycle special cases
   always_comb begin
      w       = word && XLEN == 64;
      sa      = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      sb      = op inside {OP_MULH, OP_DIV, OP_REM};
      ea      = XLEN'(wext(64'(srca), w, sa));
      eb      = XLEN'(wext(64'(srcb), w, sb));
      na      = sa && ea[XLEN-1];
      nb      = sb && eb[XLEN-1];
      ma      = na ? -ea : ea;
      mb      = nb ? -eb : eb;
      b_zero  = eb == '0;
      ovf     = (op == OP_DIV || op == OP_REM) && na && ma == (XLEN'(1) << (w ? 31 : XLEN - 1)) && &eb;
      special = (w && !op[2] && op != OP_MUL) || (op[2] && (b_zero || ovf));
      spec_r  = !op[2] ? '0 : b_zero ? (op[1] ? ea : '1) : (op[1] ? '0 : ea);
   end

   // Retire MUL_BPC multiplier bits per cycle; the product sign is folded in on the last step
   always_comb begin
      p = prod_q;
      s = '0;
      for (int i = 0; i < MUL_BPC; i++) begin
         s = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, (p[0] ? mcand_q : {XLEN{1'b0}})};
         p = {s, p[XLEN-1:1]};
      end
      if (cnt_q == '0 && neg_q) p = -p;
      mul_r = word_q ? XLEN'(p[XLEN-32 +: 32]) : op_q == OP_MUL ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
   end

   // Next-state and datapath loads; flush wins over accept and consumption
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      prod_d    = prod_q;
      mcand_d   = mcand_q;
      word_d    = word_q;
      neg_d     = neg_q;
      result_d  = result_q;
      div_start = 1'b0;
      if (flush) state_d = S_IDLE;
      else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               op_d      = op;
               word_d    = w;
               cnt_d     = CW'((w ? 32 : XLEN) / MUL_BPC - 1);
               prod_d    = {{XLEN{1'b0}}, mb};
               mcand_d   = ma;
               neg_d     = na ^ nb;
               state_d   = special ? S_DONE : op[2] ? S_DIV : S_MUL;
               div_start = !special && op[2];
               result_d  = special ? XLEN'(wext(64'(spec_r), w, 1'b1)) : result_q;
            end
            S_MUL: begin
               prod_d   = p;
               cnt_d    = cnt_q - 1'b1;
               state_d  = cnt_q == '0 ? S_DONE : S_MUL;
               result_d = cnt_q == '0 ? XLEN'(wext(64'(mul_r), word_q, 1'b1)) : result_q;
            end
            S_DIV:   state_d = div_done ? S_FIXUP : S_DIV;
            S_FIXUP: begin
               state_d  = S_DONE;
               result_d = XLEN'(wext(64'(op_q[1] ? r_fix : q_fix), word_q, 1'b1));
            end
            S_DONE:  state_d = out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State, multiplier and result registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         op_q     <= OP_MUL;
         cnt_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         word_q   <= 1'b0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         word_q   <= word_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   muldiv_divcore #(.XLEN(XLEN)) u_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (flush),
      .start    (div_start),
      .word     (w),
      .neg_quo  (na ^ nb),
      .neg_rem  (na),
      .dividend (ma),
      .divisor  (mb),
      .done     (div_done),
      .quo      (q_fix),
      .rem      (r_fix)
   );

   assign in_ready  = state_q == S_IDLE;
   assign out_valid = state_q == S_DONE;
   assign result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN=64, MUL_BPC=4)
module tb_muldiv_unit;
   import pipes::*;

   typedef struct {
      mdop_t       o;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] e;
      int          l;
   } vec_t;

   logic        clk = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, word = 1'b0, out_ready = 1'b1;
   mdop_t       op = OP_MUL;
   logic [63:0] srca = '0, srcb = '0;
   logic        in_ready, out_valid;
   logic [63:0] result;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(64), .MUL_BPC(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .word      (word),
      .srca      (srca),
      .srcb      (srcb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   // Issue one request, count edges after the accept edge until out_valid, then consume it
   task automatic run_op(input mdop_t o, input logic w, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output int lat);
      out_ready = 1'b1;
      @(posedge clk); #1;
      op = o; word = w; srca = a; srcb = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      r = result;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #1;
      total += 3;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
      if (result !== 64'd0) begin bad++; $display("FAIL reset result: got %h want 0", result); end
      #12 reset_n = 1'b1;
   endtask

   task automatic test_mul();
      vec_t v[5] = '{
         '{OP_MUL,    1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 16},
         '{OP_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 16},
         '{OP_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h0000_0000_0000_0001, 16},
         '{OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 16},
         '{OP_MULH,   1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h0000_0000_0000_0000, 0}
      };
      logic [63:0] r;
      int          lat;
      foreach (v[i]) begin
         run_op(v[i].o, v[i].w, v[i].a, v[i].b, r, lat);
         total += 2;
         if (r !== v[i].e) begin bad++; $display("FAIL mul[%0d] result: got %h want %h", i, r, v[i].e); end
         if (lat !== v[i].l) begin bad++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, v[i].l); end
      end
   endtask

   task automatic test_div();
      vec_t v[5] = '{
         '{OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65},
         '{OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65},
         '{OP_DIVU, 1'b0, 64'd7,                   64'd2, 64'h0000_0000_0000_0003, 65},
         '{OP_REMU, 1'b1, 64'h0000_0001_8000_0001, 64'd2, 64'h0000_0000_0000_0001, 33},
         '{OP_DIV,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33}
      };
      logic [63:0] r;
      int          lat;
      foreach (v[i]) begin
         run_op(v[i].o, v[i].w, v[i].a, v[i].b, r, lat);
         total += 2;
         if (r !== v[i].e) begin bad++; $display("FAIL div[%0d] result: got %h want %h", i, r, v[i].e); end
         if (lat !== v[i].l) begin bad++; $display("FAIL div[%0d] latency: got %0d want %0d", i, lat, v[i].l); end
      end
   endtask

   // Special cases go IDLE->DONE on the accept edge, so out_valid is already high right after it
   task automatic test_div_zero();
      vec_t v[3] = '{
         '{OP_DIV,  1'b0, 64'd5,                   64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 0},
         '{OP_REM,  1'b0, 64'd5,                   64'd0,                   64'h0000_0000_0000_0005, 0},
         '{OP_DIVU, 1'b1, 64'h0000_00AB_0000_0005, 64'h0000_0007_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0}
      };
      logic [63:0] r;
      int          lat;
      foreach (v[i]) begin
         run_op(v[i].o, v[i].w, v[i].a, v[i].b, r, lat);
         total += 2;
         if (r !== v[i].e) begin bad++; $display("FAIL divzero[%0d] result: got %h want %h", i, r, v[i].e); end
         if (lat !== v[i].l) begin bad++; $display("FAIL divzero[%0d] latency: got %0d want %0d", i, lat, v[i].l); end
      end
   endtask

   task automatic test_overflow();
      vec_t v[3] = '{
         '{OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0},
         '{OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 0},
         '{OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0}
      };
      logic [63:0] r;
      int          lat;
      foreach (v[i]) begin
         run_op(v[i].o, v[i].w, v[i].a, v[i].b, r, lat);
         total += 2;
         if (r !== v[i].e) begin bad++; $display("FAIL ovf[%0d] result: got %h want %h", i, r, v[i].e); end
         if (lat !== v[i].l) begin bad++; $display("FAIL ovf[%0d] latency: got %0d want %0d", i, lat, v[i].l); end
      end
   endtask

   task automatic test_backpressure();
      int n;
      out_ready = 1'b0;
      @(posedge clk); #1;
      op = OP_MUL; word = 1'b0; srca = 64'd3; srcb = 64'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
      total++;
      if (n !== 16) begin bad++; $display("FAIL bp latency: got %0d want 16", n); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         total++;
         if (result !== 64'd15 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp hold[%0d]: result=%h out_valid=%b in_ready=%b want 15/1/0", i, result, out_valid, in_ready);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL bp consume: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
      op = OP_DIVU; srca = 64'd100; srcb = 64'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp accept: in_ready=%b want 0", in_ready); end
      n = 0;
      while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
      total += 2;
      if (result !== 64'd14) begin bad++; $display("FAIL bp divu result: got %h want e", result); end
      if (n !== 65) begin bad++; $display("FAIL bp divu latency: got %0d want 65", n); end
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      logic        seen;
      logic [63:0] r;
      int          lat;
      out_ready = 1'b1;
      @(posedge clk); #1;
      op = OP_DIV; word = 1'b0; srca = 64'd1000; srcb = 64'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL flush idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
      seen = 1'b0;
      repeat (80) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL flush spurious out_valid: got %b want 0", seen); end
      run_op(OP_MUL, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, r, lat);
      total += 2;
      if (r !== 64'hFFFF_FFFF_FFFF_FFF4) begin bad++; $display("FAIL flush mulw result: got %h want fffffffffffffff4", r); end
      if (lat !== 8) begin bad++; $display("FAIL flush mulw latency: got %0d want 8", lat); end
      out_ready = 1'b0;
      op = OP_DIV; word = 1'b0; srca = 64'd5; srcb = 64'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL flush done setup: out_valid=%b want 1", out_valid); end
      flush = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL flush in done: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] r;
      int          lat;
      out_ready = 1'b1;
      @(posedge clk); #1;
      op = OP_MUL; word = 1'b0; srca = 64'd9; srcb = 64'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      total += 3;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst mid out_valid: got %b want 0", out_valid); end
      if (in_ready !== 1'b1) begin bad++; $display("FAIL rst mid in_ready: got %b want 1", in_ready); end
      if (result !== 64'd0) begin bad++; $display("FAIL rst mid result: got %h want 0", result); end
      #1 reset_n = 1'b1;
      run_op(OP_MUL, 1'b0, 64'd6, 64'd7, r, lat);
      total += 2;
      if (r !== 64'd42) begin bad++; $display("FAIL rst recover result: got %h want 2a", r); end
      if (lat !== 16) begin bad++; $display("FAIL rst recover latency: got %0d want 16", lat); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_overflow();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
